hack_screen_capture: RTL and testbench
======================================

# hack_screen_capture

Video capture block that consumes the pixel stream and blanking timing produced by the Nand2Tetris video generator and writes it back into a Hack-format screen memory of 512x256 pixels, 1 bpp, 16-bit words, 8192 words. It sits on the video output side, feeding loopback and verification paths. It also measures active frame geometry and reports lock when two consecutive frames match.

## Interface
Parameters:
- WIDTH, 512, max captured pixels per line; must be a multiple of 16
- HEIGHT, 256, max captured lines per frame
- THRESH, 8'h80, luma threshold; `video >= THRESH` gives pixel 1

Ports:
- clk  in  1  system clock; only clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  capture enable
- ce_pix  in  1  pixel strobe; all video inputs are sampled only when high
- hblank  in  1  horizontal blank, active high
- vblank  in  1  vertical blank, active high
- video  in  8  pixel luma
- wr_en  out  1  screen-memory write strobe, one clk wide
- wr_addr  out  13  word address = y*32 + x/16
- wr_data  out  16  packed pixels; bit n = pixel x%16 == n, so bit 0 is leftmost
- frame_done  out  1  one-clk pulse at end of each captured frame
- locked  out  1  geometry stable across two consecutive frames
- active_w  out  11  active pixels in last line of last frame, saturating at 2047
- active_h  out  10  active lines in last frame, saturating at 1023
- overflow  out  1  last frame had active pixels outside WIDTH x HEIGHT

## Operation
- **Active pixel:** ce_pix & !hblank & !vblank.
- **Edge detection:** hblank/vblank edges are detected from ce_pix-qualified samples only; the previous-sample registers update only on ce_pix.
- **FSM states:**
  - IDLE: entered on reset or enable=0.
  - ALIGN: enable=1; waiting for a vblank falling edge.
  - CAPTURE: entered on that edge. x, y, packer and overflow-pending are cleared on entry.
- **CAPTURE per active pixel:**
  - bit x[3:0] of the packer = (video >= THRESH); x increments.
  - When x[3:0]==15, issue a write (see Timing); the packer is cleared.
- **Line end** (hblank rising edge in CAPTURE with x>0):
  - If x[3:0]!=0, flush the partial word; unfilled bits are 0.
  - Record line width = x; then x=0, y+=1.
- **Clipping:** pixels with x>=WIDTH or y>=HEIGHT are not written; they set overflow-pending.
- **Frame end** (vblank rising edge in CAPTURE):
  - Latch active_w = last line width and active_h = y.
  - overflow = overflow-pending.
  - Pulse frame_done.
  - Go to ALIGN for the next frame.
- **Lock:**
  - locked=1 when the active_w/active_h just latched equal the previous frame's values.
  - Any mismatch clears locked.
- **enable falls:** immediate move to IDLE. No further writes, the partial word is discarded, locked=0; measurements are held.
- **Width rules:** x is 11 bits and y is 10 bits, both saturating. wr_addr = {y[7:0], x[8:4]}, issued only when in range.

## Timing
- **Reset values:** wr_en=0, wr_addr=0, wr_data=0, frame_done=0, locked=0, active_w=0, active_h=0, overflow=0; FSM=IDLE.
- **Write latency:** wr_en asserts exactly one clk after the ce_pix sample that completes a word or triggers a flush. wr_addr and wr_data are valid with wr_en and hold until the next write.
- **frame_done latency:** asserts one clk after the vblank-rising sample. The measurement outputs update in that same cycle.
- **Simultaneous hblank and vblank rise:** the flush write and frame_done may assert in the same cycle. The flush uses the final line's y.
- **ce_pix rate:** may be high every clk; the maximum write rate is one per 16 pixels (one per line end for flushes), so there is no backpressure.
- **reset_n low mid-frame:** all outputs return to reset values on the next clk edge.

## Test plan
- **Nominal frame:** enable=1, 512x256 active frame, ce_pix every 2nd clk, checkerboard (even x=0xFF, odd x=0x00) -> 8192 writes, addresses 0..8191 ascending, all wr_data=16'h5555, one frame_done, active_w=512, active_h=256, overflow=0.
- **Lock:** two identical 512x256 frames -> locked=0 after frame 1 and locked=1 after frame 2. A third frame at 512x255 -> locked=0, active_h=255.
- **Partial word flush:** 20-pixel lines, all video=0xFF, 2 lines -> writes (addr 0, 16'hFFFF), (1, 16'h000F), (32, 16'hFFFF), (33, 16'h000F); active_w=20.
- **Overflow clip:** 528x260 frame -> no write with x>=512 or y>=256, 8192 writes total, overflow=1, active_w=528, active_h=260.
- **Threshold boundary:** video 0x7F vs 0x80 at x=0 and x=1 -> wr_data[0]=0, wr_data[1]=1.
- **Abort:**
  - enable dropped at line 10, x=8 -> no further wr_en, locked=0, no frame_done.
  - enable re-raised mid-frame -> capture resumes only after the next vblank falling edge.
  - reset_n low mid-line -> all outputs 0 next clk.

Source files
------------

// File: rtl/hack_screen_capture.sv
`default_nettype none
// hack_screen_capture: packs a blanked luma stream into 1-bpp Hack screen-memory word writes,
// measures the active frame geometry and reports lock when consecutive frames agree.
module hack_screen_capture #(
  parameter int         WIDTH  = 512,
  parameter int         HEIGHT = 256,
  parameter logic [7:0] THRESH = 8'h80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_pix,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [7:0]  video,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic [10:0] active_w,
  output logic [9:0]  active_h,
  output logic        overflow
);

  localparam logic [11:0] X_LIMIT = 12'(WIDTH);
  localparam logic [10:0] Y_LIMIT = 11'(HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, CAPTURE = 2'd2} state_t;
  state_t state, state_next;

  logic        prev_hblank, prev_vblank;
  logic [10:0] x, line_w;
  logic [9:0]  y;
  logic [15:0] packer;
  logic        ovf_pend;

  // Blanking edges only ever compare two ce_pix-qualified samples.
  logic hb_rise, vb_rise, vb_fall, active_pix;
  assign hb_rise    = ce_pix & hblank & ~prev_hblank;
  assign vb_rise    = ce_pix & vblank & ~prev_vblank;
  assign vb_fall    = ce_pix & ~vblank & prev_vblank;
  assign active_pix = ce_pix & ~hblank & ~vblank;

  logic start_capture, pixel_step, line_end, frame_end;

  always_comb begin
    state_next    = state;
    start_capture = 1'b0;
    pixel_step    = 1'b0;
    line_end      = 1'b0;
    frame_end     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, ALIGN: begin
          if (vb_fall) begin
            state_next    = CAPTURE;
            start_capture = 1'b1;
          end else begin
            state_next = ALIGN;
          end
        end
        CAPTURE: begin
          pixel_step = active_pix;
          line_end   = hb_rise && (x != 11'd0);
          if (vb_rise) begin
            frame_end  = 1'b1;
            state_next = ALIGN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  logic        in_range, pix_bit, word_done, flush;
  logic [10:0] x_inc, line_w_next;
  logic [9:0]  y_inc, y_after;
  logic [15:0] packed_word;

  assign in_range    = ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
  assign pix_bit     = (video >= THRESH);
  assign x_inc       = (x == 11'h7FF) ? x : x + 11'd1;
  assign y_inc       = (y == 10'h3FF) ? y : y + 10'd1;
  assign packed_word = packer | (16'(pix_bit) << x[3:0]);
  assign word_done   = pixel_step && (x[3:0] == 4'hF);
  assign flush       = line_end && (x[3:0] != 4'h0);
  // A line end coinciding with frame end must be folded into the latched geometry.
  assign y_after     = line_end ? y_inc : y;
  assign line_w_next = line_end ? x : line_w;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_hblank <= 1'b0;
      prev_vblank <= 1'b0;
      x           <= 11'd0;
      y           <= 10'd0;
      line_w      <= 11'd0;
      packer      <= 16'h0000;
      ovf_pend    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 13'd0;
      wr_data     <= 16'h0000;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
      active_w    <= 11'd0;
      active_h    <= 10'd0;
      overflow    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (ce_pix) begin
        prev_hblank <= hblank;
        prev_vblank <= vblank;
      end
      if (!enable) locked <= 1'b0;
      if (start_capture) begin
        x        <= 11'd0;
        y        <= 10'd0;
        packer   <= 16'h0000;
        ovf_pend <= 1'b0;
      end
      if (pixel_step) begin
        x      <= x_inc;
        packer <= word_done ? 16'h0000 : packed_word;
        if (!in_range) begin
          ovf_pend <= 1'b1;
        end else if (word_done) begin
          wr_en   <= 1'b1;
          wr_addr <= {y[7:0], x[8:4]};
          wr_data <= packed_word;
        end
      end
      if (line_end) begin
        if (flush && in_range) begin
          wr_en   <= 1'b1;
          wr_addr <= {y[7:0], x[8:4]};
          wr_data <= packer;
        end
        packer <= 16'h0000;
        line_w <= x;
        x      <= 11'd0;
        y      <= y_inc;
      end
      if (frame_end) begin
        active_w   <= line_w_next;
        active_h   <= y_after;
        overflow   <= ovf_pend;
        frame_done <= 1'b1;
        locked     <= (line_w_next == active_w) && (y_after == active_h);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_screen_capture.sv
`default_nettype none
// Randomized bench for hack_screen_capture; expected writes and geometry come from a
// picture-level model (pixel luma function, frame line widths) rather than the RTL structure.
module tb_hack_screen_capture;
  logic        clk = 1'b0;
  logic        reset_n, enable, ce_pix, hblank, vblank;
  logic [7:0]  video;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done, locked, overflow;
  logic [10:0] active_w;
  logic [9:0]  active_h;

  hack_screen_capture dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .video(video),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked),
    .active_w(active_w), .active_h(active_h), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_addr[$];
  int exp_data[$];
  int due_q[$];
  int fd_count = 0;
  int fd_exp = 0;
  int prev_aw = 0;
  int prev_ah = 0;
  int mon_due, mon_a, mon_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Write monitor: every wr_en must match the next expected word and its due cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (wr_en === 1'b1) begin
      if (exp_addr.size() == 0) begin
        check("wr_extra", 64'(wr_en), 64'd0);
      end else begin
        mon_a = exp_addr.pop_front();
        mon_d = exp_data.pop_front();
        mon_due = (due_q.size() > 0) ? due_q[0] : -1;
        if (due_q.size() > 0) due_q.delete(0);
        check("wr_addr", 64'(wr_addr), 64'(mon_a));
        check("wr_data", 64'(wr_data), 64'(mon_d));
        check("wr_cycle", 64'(cyc), 64'(mon_due));
      end
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("wr_missing", 64'(wr_en), 64'd1);
      due_q.delete(0);
      if (exp_addr.size() > 0) begin
        exp_addr.delete(0);
        exp_data.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic h, input logic v, input logic [7:0] vid, input bit due);
    ce_pix = 1'b1;
    hblank = h;
    vblank = v;
    video  = vid;
    tick();
    if (due) due_q.push_back(cyc);
  endtask

  // ce_pix-low gap with garbage on the video inputs.
  task automatic idle(input int gap);
    int k;
    k = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    repeat (k) begin
      ce_pix = 1'b0;
      hblank = 1'($urandom);
      vblank = 1'($urandom);
      video  = 8'($urandom);
      tick();
    end
  endtask

  function automatic logic [7:0] lum(input int mode, input int unsigned seed, input int y, input int x);
    int unsigned h;
    h = (32'(x) * 32'h9E3779B1) ^ (32'(y) * 32'h85EBCA6B) ^ seed;
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 13);
    case (mode)
      1:       lum = 8'hFF;
      2:       lum = (x % 2 == 0) ? 8'hFF : 8'h00;
      3:       lum = (x == 0) ? 8'h7F : (x == 1) ? 8'h80 : (h[20] ? 8'h80 : 8'h7F);
      default: lum = h[31:24];
    endcase
  endfunction

  function automatic int width_of(input int y, input int n, input int fw, input int w, input int lw);
    if (y == n - 1) return lw;
    if (y == 0) return fw;
    return w;
  endfunction

  // Screen-memory words a visible line produces: column c holds pixels 16c..16c+15, bit b = pixel 16c+b.
  function automatic void expect_line(input int y, input int wy, input int mode, input int unsigned seed);
    logic [15:0] d;
    if (y >= 256) return;
    for (int c = 0; c < 32 && 16 * c < wy; c++) begin
      d = 16'h0000;
      for (int b = 0; b < 16; b++)
        if (16 * c + b < wy) d[b] = (lum(mode, seed, y, 16 * c + b) >= 8'h80);
      exp_addr.push_back(y * 32 + c);
      exp_data.push_back(int'(d));
    end
  endfunction

  task automatic frame_end_check(input bit cap, input int wy, input int n, input bit ov);
    int aw, ah;
    if (cap) begin
      aw = (wy > 2047) ? 2047 : wy;
      ah = (n > 1023) ? 1023 : n;
      check("frame_done", 64'(frame_done), 64'd1);
      check("active_w", 64'(active_w), 64'(aw));
      check("active_h", 64'(active_h), 64'(ah));
      check("overflow", 64'(overflow), 64'(ov));
      check("locked", 64'(locked), 64'((aw == prev_aw) && (ah == prev_ah)));
      prev_aw = aw;
      prev_ah = ah;
      fd_exp++;
    end else begin
      check("no_frame_done", 64'(frame_done), 64'd0);
      check("locked_off", 64'(locked), 64'd0);
      check("held_w", 64'(active_w), 64'(prev_aw));
      check("held_h", 64'(active_h), 64'(prev_ah));
    end
  endtask

  // stop_kind 1 drops enable, 2 pulses reset_n, at (stop_line, x=8); en_line raises enable at x=5.
  task automatic drive_frame(input int n, input int fw, input int w, input int lw, input int mode,
                             input int gap, input bit sim, input int stop_line, input int stop_kind,
                             input int en_line);
    int unsigned seed;
    bit cap, ov, due;
    int wy, lines;
    seed   = $urandom;
    enable = (en_line < 0);
    cap    = (en_line < 0);
    ov     = 1'b0;
    lines  = (stop_line >= 0 && stop_line < n) ? stop_line : n;
    if (cap)
      for (int y = 0; y < lines; y++) expect_line(y, width_of(y, n, fw, w, lw), mode, seed);
    for (int k = 0; k < 3; k++) begin
      sample(1'b1, 1'b1, 8'($urandom), 1'b0);
      idle(gap);
    end
    sample(1'b1, 1'b0, 8'($urandom), 1'b0);
    idle(gap);
    for (int y = 0; y < n; y++) begin
      wy = width_of(y, n, fw, w, lw);
      if (wy > 512 || y >= 256) ov = 1'b1;
      for (int x = 0; x < wy; x++) begin
        if (y == stop_line && x == 8) begin
          if (stop_kind == 2) begin
            check("exp_left_rst", 64'(exp_addr.size()), 64'd0);
            reset_n = 1'b0;
            ce_pix  = 1'b0;
            tick();
            check("rst_wr_en", 64'(wr_en), 64'd0);
            check("rst_wr_addr", 64'(wr_addr), 64'd0);
            check("rst_wr_data", 64'(wr_data), 64'd0);
            check("rst_frame_done", 64'(frame_done), 64'd0);
            check("rst_locked", 64'(locked), 64'd0);
            check("rst_active_w", 64'(active_w), 64'd0);
            check("rst_active_h", 64'(active_h), 64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
            reset_n = 1'b1;
            prev_aw = 0;
            prev_ah = 0;
            return;
          end
          enable = 1'b0;
          cap    = 1'b0;
        end
        if (y == en_line && x == 5) enable = 1'b1;
        due = cap && (x % 16 == 15) && (x < 512) && (y < 256);
        sample(1'b0, 1'b0, lum(mode, seed, y, x), due);
        idle(gap);
      end
      due = cap && (wy % 16 != 0) && (wy < 512) && (y < 256);
      if (y == n - 1) begin
        if (sim) begin
          sample(1'b1, 1'b1, 8'($urandom), due);
        end else begin
          sample(1'b1, 1'b0, 8'($urandom), due);
          idle(gap);
          sample(1'b1, 1'b1, 8'($urandom), 1'b0);
        end
        frame_end_check(cap, wy, n, ov);
      end else begin
        sample(1'b1, 1'b0, 8'($urandom), due);
        idle(gap);
        sample(1'b1, 1'b0, 8'($urandom), 1'b0);
      end
      idle(gap);
    end
    for (int k = 0; k < 3; k++) begin
      sample(1'b1, 1'b1, 8'($urandom), 1'b0);
      idle(gap);
    end
    check("exp_left", 64'(exp_addr.size()), 64'd0);
    check("fd_count", 64'(fd_count), 64'(fd_exp));
  endtask

  int rn, rfw, rw, rlw;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    ce_pix  = 1'b0;
    hblank  = 1'b0;
    vblank  = 1'b0;
    video   = 8'h00;
    repeat (3) tick();
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_active_w", 64'(active_w), 64'd0);
    check("reset_active_h", 64'(active_h), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    drive_frame(6, 48, 48, 48, 2, 1, 1'b0, -1, 0, -1);    // checkerboard -> 16'h5555 words
    drive_frame(6, 48, 48, 48, 0, 0, 1'b0, -1, 0, -1);    // same geometry -> locked
    drive_frame(5, 48, 48, 48, 0, 2, 1'b0, -1, 0, -1);    // one line fewer -> unlocked
    drive_frame(2, 20, 20, 20, 1, 0, 1'b0, -1, 0, -1);    // partial-word flush
    drive_frame(2, 16, 16, 16, 3, 1, 1'b0, -1, 0, -1);    // threshold 0x7F / 0x80
    drive_frame(260, 528, 20, 40, 0, 0, 1'b0, -1, 0, -1); // clipping in x and y
    drive_frame(3, 528, 16, 32, 0, 1, 1'b0, -1, 0, -1);   // x-only overflow
    drive_frame(3, 37, 37, 21, 0, 1, 1'b1, -1, 0, -1);    // hblank and vblank rise together

    rn = 4; rfw = 33; rw = 33; rlw = 33;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(1, 0) == 0) begin
        rn  = $urandom_range(10, 1);
        rfw = $urandom_range(100, 1);
        rw  = $urandom_range(100, 1);
        rlw = $urandom_range(100, 1);
      end
      drive_frame(rn, rfw, rw, rlw, $urandom_range(3, 0), $urandom_range(2, 0),
                  1'($urandom), -1, 0, -1);
    end

    drive_frame(14, 40, 40, 40, 0, 1, 1'b0, 10, 1, -1);   // enable drops at line 10, x=8
    drive_frame(8, 40, 40, 40, 0, 1, 1'b0, -1, 0, 3);     // enable returns mid-frame
    drive_frame(8, 40, 40, 40, 0, 1, 1'b0, -1, 0, -1);
    drive_frame(5, 40, 40, 40, 0, 1, 1'b0, 2, 2, -1);     // reset mid-line
    drive_frame(4, 24, 24, 24, 0, 1, 1'b0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
